// File: rtl/ld_sched_pkg.sv
// Shared types and width helpers for the lane-detection frame scheduler.
// Pure declarations, no logic.
// No flow control here.
package ld_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        STREAM,
        PAD,
        WAIT_RES
    } state_e;

    typedef enum logic {
        LINE,
        FRAME
    } pad_mode_e;

    // Bits needed to index 0..n-1 along a line.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Bits needed to index 0..n-1 down the frame.
    function automatic int row_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ld_pos_counter.sv
// Column/row position tracker for the output pixel stream.
// Latency: eol/eof reflect the current registered position; updates one cycle after inc.
// Backpressure: none; the caller pulses inc only on a completed output beat.
module ld_pos_counter
    import ld_sched_pkg::*;
#(
    parameter int IMG_WIDTH  = 416,
    parameter int IMG_LENGTH = 416
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic eol,
    output logic eof
);

    localparam int COL_BITS = cnt_w(IMG_WIDTH);
    localparam int ROW_BITS = row_w(IMG_LENGTH);

    logic [COL_BITS-1:0] col_q, col_d;
    logic [ROW_BITS-1:0] row_q, row_d;

    assign eol = (col_q == COL_BITS'(IMG_WIDTH - 1));
    assign eof = eol && (row_q == ROW_BITS'(IMG_LENGTH - 1));

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clr) begin
            col_d = '0;
            row_d = '0;
        end else if (inc) begin
            if (eol) begin
                col_d = '0;
                row_d = eof ? '0 : row_q + ROW_BITS'(1);
            end else begin
                col_d = col_q + COL_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/ld_frame_scheduler.sv
// Frame sequencer in front of the lane-detection pipeline: SOF align, pad/trim, result latch.
// Latency: zero-cycle pass-through while streaming; res_* and timeout appear one cycle after the event.
// Backpressure: s_axis_tready follows m_axis_tready while streaming; LD_SCHED_WATCHDOG_EN adds a WAIT_RES timeout.
module ld_frame_scheduler
    import ld_sched_pkg::*;
#(
    parameter int                   AXI_WIDTH   = 24,
    parameter int                   IMG_WIDTH   = 416,
    parameter int                   IMG_LENGTH  = 416,
    parameter logic [AXI_WIDTH-1:0] PAD_VALUE   = '0,
    parameter int                   WDOG_CYCLES = 2**20,
    localparam int                  CW          = $clog2(IMG_WIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [AXI_WIDTH-1:0] s_axis_tdata,
    input  logic                 s_axis_tvalid,
    input  logic                 s_axis_tuser,
    input  logic                 s_axis_tlast,
    output logic                 s_axis_tready,
    output logic [AXI_WIDTH-1:0] m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    input  logic                 ld_valid,
    input  logic [3:0]           ld_lanes,
    input  logic [3:0]           ld_cur_lane,
    input  logic [CW-1:0]        ld_left,
    input  logic [CW-1:0]        ld_right,
    output logic                 res_valid,
    output logic [3:0]           res_lanes,
    output logic [3:0]           res_cur_lane,
    output logic [CW-1:0]        res_left,
    output logic [CW-1:0]        res_right,
    output logic                 busy,
    output logic [15:0]          frames_done,
    output logic [15:0]          frames_dropped,
    output logic                 timeout
);

    state_e         state_q, state_d;
    pad_mode_e      pad_mode_q, pad_mode_d;
    logic           drop_q, drop_d;
    logic [15:0]    frames_done_q, frames_done_d;
    logic [15:0]    frames_dropped_q, frames_dropped_d;
    logic           res_valid_q, res_valid_d;
    logic [3:0]     res_lanes_q, res_lanes_d;
    logic [3:0]     res_cur_lane_q, res_cur_lane_d;
    logic [CW-1:0]  res_left_q, res_left_d;
    logic [CW-1:0]  res_right_q, res_right_d;

    logic pos_inc;
    logic pos_clr;
    logic pos_eol;
    logic pos_eof;
    logic wait_enter;

`ifdef LD_SCHED_WATCHDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES) + 1;

    logic              timeout_q, timeout_d;
    logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;

    // Counts only while parked in WAIT_RES, so every entry starts from zero.
    assign wdog_cnt_d = (state_q == WAIT_RES) ? wdog_cnt_q + WDOG_W'(1) : '0;
    assign timeout    = timeout_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timeout_q  <= 1'b0;
            wdog_cnt_q <= '0;
        end else begin
            timeout_q  <= timeout_d;
            wdog_cnt_q <= wdog_cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    ld_pos_counter #(
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_LENGTH (IMG_LENGTH)
    ) u_pos (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (pos_inc),
        .clr   (pos_clr),
        .eol   (pos_eol),
        .eof   (pos_eof)
    );

    always_comb begin
        state_d          = state_q;
        pad_mode_d       = pad_mode_q;
        drop_d           = drop_q;
        frames_done_d    = frames_done_q;
        frames_dropped_d = frames_dropped_q;
        res_valid_d      = 1'b0;
        res_lanes_d      = res_lanes_q;
        res_cur_lane_d   = res_cur_lane_q;
        res_left_d       = res_left_q;
        res_right_d      = res_right_q;
`ifdef LD_SCHED_WATCHDOG_EN
        timeout_d        = 1'b0;
`endif
        s_axis_tready    = 1'b0;
        m_axis_tvalid    = 1'b0;
        m_axis_tdata     = '0;
        pos_inc          = 1'b0;
        pos_clr          = 1'b0;
        wait_enter       = 1'b0;

        unique case (state_q)
            IDLE: begin
                pos_clr = 1'b1;
                if (enable) state_d = SYNC;
            end

            SYNC: begin
                if (s_axis_tvalid && s_axis_tuser) begin
                    m_axis_tvalid = 1'b1;
                    m_axis_tdata  = s_axis_tdata;
                    s_axis_tready = m_axis_tready;
                    if (m_axis_tready) begin
                        pos_inc = 1'b1;
                        drop_d  = 1'b0;
                        state_d = STREAM;
                    end
                end else begin
                    s_axis_tready = 1'b1;
                    // Only abandon the hunt when no SOF beat is on offer downstream.
                    if (!enable) state_d = IDLE;
                end
            end

            STREAM: begin
                if (s_axis_tvalid && s_axis_tuser) begin
                    pad_mode_d = FRAME;
                    drop_d     = 1'b0;
                    state_d    = PAD;
                end else if (drop_q) begin
                    s_axis_tready = 1'b1;
                    if (s_axis_tvalid && s_axis_tlast) drop_d = 1'b0;
                end else begin
                    m_axis_tvalid = s_axis_tvalid;
                    m_axis_tdata  = s_axis_tdata;
                    s_axis_tready = m_axis_tready;
                    if (s_axis_tvalid && m_axis_tready) begin
                        pos_inc = 1'b1;
                        if (pos_eof) begin
                            wait_enter = 1'b1;
                        end else if (pos_eol) begin
                            drop_d = !s_axis_tlast;
                        end else if (s_axis_tlast) begin
                            pad_mode_d = LINE;
                            state_d    = PAD;
                        end
                    end
                end
            end

            PAD: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = PAD_VALUE;
                if (m_axis_tready) begin
                    pos_inc = 1'b1;
                    if (pos_eof) begin
                        wait_enter = 1'b1;
                    end else if (pos_eol && (pad_mode_q == LINE)) begin
                        state_d = STREAM;
                    end
                end
            end

            WAIT_RES: begin
                pos_clr       = 1'b1;
                s_axis_tready = 1'b1;
                if (s_axis_tvalid && s_axis_tuser && (frames_dropped_q != 16'hFFFF)) begin
                    frames_dropped_d = frames_dropped_q + 16'd1;
                end
                if (ld_valid) begin
                    res_valid_d    = 1'b1;
                    res_lanes_d    = ld_lanes;
                    res_cur_lane_d = ld_cur_lane;
                    res_left_d     = ld_left;
                    res_right_d    = ld_right;
                    state_d        = enable ? SYNC : IDLE;
                end
`ifdef LD_SCHED_WATCHDOG_EN
                else if (wdog_cnt_q == WDOG_W'(WDOG_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = enable ? SYNC : IDLE;
                end
`endif
            end

            default: state_d = IDLE;
        endcase

        if (wait_enter) begin
            state_d       = WAIT_RES;
            drop_d        = 1'b0;
            frames_done_d = frames_done_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            pad_mode_q       <= LINE;
            drop_q           <= 1'b0;
            frames_done_q    <= '0;
            frames_dropped_q <= '0;
            res_valid_q      <= 1'b0;
            res_lanes_q      <= '0;
            res_cur_lane_q   <= '0;
            res_left_q       <= '0;
            res_right_q      <= '0;
        end else begin
            state_q          <= state_d;
            pad_mode_q       <= pad_mode_d;
            drop_q           <= drop_d;
            frames_done_q    <= frames_done_d;
            frames_dropped_q <= frames_dropped_d;
            res_valid_q      <= res_valid_d;
            res_lanes_q      <= res_lanes_d;
            res_cur_lane_q   <= res_cur_lane_d;
            res_left_q       <= res_left_d;
            res_right_q      <= res_right_d;
        end
    end

    assign busy           = (state_q != IDLE);
    assign frames_done    = frames_done_q;
    assign frames_dropped = frames_dropped_q;
    assign res_valid      = res_valid_q;
    assign res_lanes      = res_lanes_q;
    assign res_cur_lane   = res_cur_lane_q;
    assign res_left       = res_left_q;
    assign res_right      = res_right_q;

endmodule

// File: tb/tb_ld_frame_scheduler.sv
// Scoreboard bench for ld_frame_scheduler on an 8x4 frame.
`timescale 1ns/1ps
module tb_ld_frame_scheduler;

    localparam int AW = 24;
    localparam int IW = 8;
    localparam int IL = 4;
    localparam int WD = 64;
    localparam int CW = $clog2(IW) + 1;

    typedef struct packed {
        logic          pad;
        logic [AW-1:0] dat;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [AW-1:0] s_tdata;
    logic          s_tvalid, s_tuser, s_tlast, s_tready;
    logic [AW-1:0] m_tdata;
    logic          m_tvalid, m_tready;
    logic          ld_valid;
    logic [3:0]    ld_lanes, ld_cur_lane;
    logic [CW-1:0] ld_left, ld_right;
    logic          res_valid;
    logic [3:0]    res_lanes, res_cur_lane;
    logic [CW-1:0] res_left, res_right;
    logic          busy, timeout;
    logic [15:0]   frames_done, frames_dropped;

    int   vectors     = 0;
    int   miscompares = 0;
    bit   rand_ready  = 1'b0;
    bit   gap_mode    = 1'b0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    ld_frame_scheduler #(
        .AXI_WIDTH   (AW),
        .IMG_WIDTH   (IW),
        .IMG_LENGTH  (IL),
        .PAD_VALUE   ('0),
        .WDOG_CYCLES (WD)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .s_axis_tdata   (s_tdata),
        .s_axis_tvalid  (s_tvalid),
        .s_axis_tuser   (s_tuser),
        .s_axis_tlast   (s_tlast),
        .s_axis_tready  (s_tready),
        .m_axis_tdata   (m_tdata),
        .m_axis_tvalid  (m_tvalid),
        .m_axis_tready  (m_tready),
        .ld_valid       (ld_valid),
        .ld_lanes       (ld_lanes),
        .ld_cur_lane    (ld_cur_lane),
        .ld_left        (ld_left),
        .ld_right       (ld_right),
        .res_valid      (res_valid),
        .res_lanes      (res_lanes),
        .res_cur_lane   (res_cur_lane),
        .res_left       (res_left),
        .res_right      (res_right),
        .busy           (busy),
        .frames_done    (frames_done),
        .frames_dropped (frames_dropped),
        .timeout        (timeout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [AW-1:0] d, input logic p);
        exp_t e;
        e.pad = p;
        e.dat = d;
        exp_q.push_back(e);
    endtask

    // Offer one source beat and hold it until accepted.
    task automatic send(input logic [AW-1:0] d, input logic u, input logic l);
        int n;
        n = 0;
        if (gap_mode) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        s_tdata  = d;
        s_tuser  = u;
        s_tlast  = l;
        s_tvalid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!s_tready && n < 2000);
        if (!s_tready) begin
            vectors++;
            miscompares++;
            $display("FAIL send_accept: beat %0h never accepted, required acceptance", d);
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tuser  = 1'b0;
        s_tlast  = 1'b0;
    endtask

    // Row of nbeats source pixels; only the first IW are forwarded, short rows padded.
    task automatic send_row(input logic [7:0] tag, input int row, input int nbeats,
                            input bit sof, input bit with_last);
        logic [AW-1:0] d;
        for (int c = 0; c < nbeats && c < IW; c++) begin
            d = {tag, 8'(row), 8'(c)};
            push(d, 1'b0);
        end
        if (with_last) begin
            for (int c = nbeats; c < IW; c++) push('0, 1'b1);
        end
        for (int c = 0; c < nbeats; c++) begin
            d = {tag, 8'(row), 8'(c)};
            send(d, sof && (c == 0), with_last && (c == nbeats - 1));
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d beats outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic end_frame(input logic [3:0] ln, input logic [3:0] cu,
                             input logic [CW-1:0] l, input logic [CW-1:0] r,
                             input logic [15:0] exp_done);
        wait_drain();
        @(negedge clk);
        check("wait_busy", busy, 1);
        check("wait_s_tready", s_tready, 1);
        check("wait_m_tvalid", m_tvalid, 0);
        check("frames_done", frames_done, exp_done);
        @(posedge clk);
        #1;
        ld_valid    = 1'b1;
        ld_lanes    = ln;
        ld_cur_lane = cu;
        ld_left     = l;
        ld_right    = r;
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
        @(negedge clk);
        check("res_valid_pulse", res_valid, 1);
        check("res_lanes", res_lanes, ln);
        check("res_cur_lane", res_cur_lane, cu);
        check("res_left", res_left, l);
        check("res_right", res_right, r);
        @(negedge clk);
        check("res_valid_low", res_valid, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_tready = rand_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every output handshake and checks stall stability.
    initial begin
        exp_t          e;
        bit            stall_pend;
        logic [AW-1:0] stall_dat;
        stall_pend = 1'b0;
        stall_dat  = '0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                stall_pend = 1'b0;
                continue;
            end
            if (stall_pend) begin
                check("hold_m_tvalid", m_tvalid, 1);
                check("hold_m_tdata", m_tdata, stall_dat);
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_beat: got %0h, required no beat", m_tdata);
                end else begin
                    e = exp_q.pop_front();
                    check("m_tdata", m_tdata, e.dat);
                    if (e.pad) check("pad_s_tready", s_tready, 0);
                end
                stall_pend = 1'b0;
            end else if (m_tvalid) begin
                stall_pend = 1'b1;
                stall_dat  = m_tdata;
            end else begin
                stall_pend = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int to_first, to_count;
        rst_n       = 1'b0;
        enable      = 1'b0;
        s_tdata     = '0;
        s_tvalid    = 1'b0;
        s_tuser     = 1'b0;
        s_tlast     = 1'b0;
        ld_valid    = 1'b0;
        ld_lanes    = '0;
        ld_cur_lane = '0;
        ld_left     = '0;
        ld_right    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_s_tready", s_tready, 0);
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_frames_done", frames_done, 0);
        check("rst_frames_dropped", frames_dropped, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_timeout", timeout, 0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        enable = 1'b1;

        // 1: clean frame preceded by two non-SOF beats that SYNC discards
        send(24'hDEAD01, 1'b0, 1'b0);
        send(24'hDEAD02, 1'b0, 1'b1);
        for (int r = 0; r < IL; r++) send_row(8'h01, r, IW, r == 0, 1'b1);
        end_frame(4'd3, 4'd2, 4'd5, 4'd9, 16'd1);
        ld_valid = 1'b1;
        ld_lanes = 4'd9;
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
        @(negedge clk);
        check("ignored_res_valid", res_valid, 0);
        check("ignored_res_lanes", res_lanes, 3);
        @(posedge clk);
        #1;

        // 2: short row 1 (tlast at col 4) padded with 3 beats
        send_row(8'h02, 0, IW, 1'b1, 1'b1);
        send_row(8'h02, 1, 5, 1'b0, 1'b1);
        send_row(8'h02, 2, IW, 1'b0, 1'b1);
        send_row(8'h02, 3, IW, 1'b0, 1'b1);
        end_frame(4'd2, 4'd1, 4'd3, 4'd7, 16'd2);

        // 3: long row 2 of 10 beats, beats 9 and 10 trimmed
        send_row(8'h03, 0, IW, 1'b1, 1'b1);
        send_row(8'h03, 1, IW, 1'b0, 1'b1);
        send_row(8'h03, 2, 10, 1'b0, 1'b1);
        send_row(8'h03, 3, IW, 1'b0, 1'b1);
        end_frame(4'd4, 4'd3, 4'd1, 4'd8, 16'd3);

        // 4: new SOF at pixel 20 -> 12 pads, SOF discarded in WAIT_RES
        send_row(8'h04, 0, IW, 1'b1, 1'b1);
        send_row(8'h04, 1, IW, 1'b0, 1'b1);
        send_row(8'h04, 2, 4, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) push('0, 1'b1);
        send(24'h04FF00, 1'b1, 1'b0);
        @(negedge clk);
        check("frames_dropped", frames_dropped, 1);
        end_frame(4'd1, 4'd0, 4'd2, 4'd6, 16'd4);

        // 5: 30% sink duty and source gaps
        rand_ready = 1'b1;
        gap_mode   = 1'b1;
        for (int r = 0; r < IL; r++) send_row(8'h05, r, IW, r == 0, 1'b1);
        wait_drain();
        rand_ready = 1'b0;
        gap_mode   = 1'b0;
        end_frame(4'd2, 4'd2, 4'd4, 4'd12, 16'd5);

        // 6: no decision from the pipeline
        for (int r = 0; r < IL; r++) send_row(8'h06, r, IW, r == 0, 1'b1);
        wait_drain();
        to_first = 0;
        to_count = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (timeout) begin
                to_count++;
                if (to_first == 0) to_first = k;
            end
        end
`ifdef LD_SCHED_WATCHDOG_EN
        check("timeout_cycle", to_first, 65);
        check("timeout_width", to_count, 1);
        check("timeout_res_lanes", res_lanes, 2);
        check("after_timeout_busy", busy, 1);
        check("after_timeout_frames_done", frames_done, 6);
        @(posedge clk);
        #1;
`else
        check("no_timeout", to_count, 0);
        check("still_wait_busy", busy, 1);
        check("still_wait_res_valid", res_valid, 0);
        @(posedge clk);
        #1;
        end_frame(4'd1, 4'd1, 4'd1, 4'd2, 16'd6);
`endif
        send_row(8'h07, 0, 5, 1'b1, 1'b0);
        wait_drain();
        s_tdata  = 24'h070005;
        s_tvalid = 1'b1;
        rst_n    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_m_tvalid", m_tvalid, 0);
        check("midrst_m_tdata", m_tdata, 0);
        check("midrst_s_tready", s_tready, 0);
        check("midrst_frames_done", frames_done, 0);
        check("midrst_frames_dropped", frames_dropped, 0);
        check("midrst_res_lanes", res_lanes, 0);
        check("midrst_res_left", res_left, 0);
        check("midrst_res_valid", res_valid, 0);
        check("midrst_timeout", timeout, 0);
        s_tvalid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
